// File: rtl/accelerator_pkg.sv
// Shared types and constants for the OBI data responder.
package accelerator_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    STALL = 1'b1
  } obi_resp_state_t;

  localparam logic [7:0] OOB_SAT_MAX = 8'hFF;

  function automatic logic [7:0] oob_sat_inc(input logic [7:0] value);
    return (value == OOB_SAT_MAX) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/obi_data_responder_if.sv
// OBI data-side request/response bundle between an initiator and the responder.
interface obi_data_responder_if;
  logic        data_req_i;
  logic        data_gnt_o;
  logic [31:0] data_addr_i;
  logic        data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_wdata_i;
  logic        data_rvalid_o;
  logic [31:0] data_rdata_o;

  modport master (
    output data_req_i, data_addr_i, data_we_i, data_be_i, data_wdata_i,
    input  data_gnt_o, data_rvalid_o, data_rdata_o
  );

  modport slave (
    input  data_req_i, data_addr_i, data_we_i, data_be_i, data_wdata_i,
    output data_gnt_o, data_rvalid_o, data_rdata_o
  );
endinterface

// File: rtl/obi_resp_bytemem.sv
// Byte-lane RAM: one byte-enabled bus write port, a whole-word preload port and
// an asynchronous read. Callers keep the two writes off the same word.
module obi_resp_bytemem #(
  parameter  int DEPTH_WORDS = 256,
  localparam int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [3:0]    be,
  input  logic [31:0]   wdata,
  input  logic          init_we,
  input  logic [AW-1:0] init_addr,
  input  logic [31:0]   init_wdata,
  output logic [31:0]   rdata
);

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] lane_mem [DEPTH_WORDS];

    // Bus write is issued last so it takes priority on a shared word.
    always_ff @(posedge clk) begin
      if (init_we) begin
        lane_mem[init_addr] <= init_wdata[8*gi +: 8];
      end
      if (we && be[gi]) begin
        lane_mem[addr] <= wdata[8*gi +: 8];
      end
    end

    assign rdata[8*gi +: 8] = lane_mem[addr];
  end

endmodule

// File: rtl/obi_data_responder.sv
// OBI data responder backed by a byte-enabled RAM. Optional grant wait states
// are compiled in with OBI_RESPONDER_STALL_EN.
module obi_data_responder
  import accelerator_pkg::*;
#(
  parameter int          DEPTH_WORDS = 256,
  parameter logic [31:0] BAD_DATA    = 32'hDEAD_BEEF
) (
  input  logic                    clk,
  input  logic                    n_reset,
  obi_data_responder_if.slave     bus,
  input  logic [3:0]              stall_cycles_i,
  input  logic                    init_we_i,
  input  logic [11:0]             init_addr_i,
  input  logic [31:0]             init_wdata_i,
  output logic [7:0]              oob_count_o
);

  localparam int          AW          = $clog2(DEPTH_WORDS);
  localparam logic [29:0] DEPTH_LIMIT = 30'(DEPTH_WORDS);
  localparam logic [12:0] INIT_LIMIT  = 13'(DEPTH_WORDS);

  logic          gnt_raw;
  logic          gnt;
  logic          in_range;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [31:0]   mem_rdata;
  logic          init_in_range;
  logic          init_we_eff;
  logic          rvalid_reg;
  logic [31:0]   rdata_reg, rdata_next;
  logic [7:0]    oob_reg, oob_next;
  logic          unused_addr;

  assign in_range    = bus.data_addr_i[31:2] < DEPTH_LIMIT;
  assign mem_addr    = bus.data_addr_i[AW+1:2];
  assign unused_addr = ^bus.data_addr_i[1:0];

`ifdef OBI_RESPONDER_STALL_EN
  obi_resp_state_t state_reg, state_next;
  logic [3:0]      count_reg, count_next;

  always_ff @(posedge clk) begin
    if (n_reset) begin
      state_reg <= IDLE;
      count_reg <= 4'd0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    gnt_raw    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.data_req_i) begin
          if (stall_cycles_i == 4'd0) begin
            gnt_raw = 1'b1;
          end else begin
            count_next = stall_cycles_i;
            state_next = STALL;
          end
        end
      end
      STALL: begin
        count_next = count_reg - 4'd1;
        if (count_reg == 4'd1) begin
          gnt_raw    = 1'b1;
          count_next = 4'd0;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        count_next = 4'd0;
      end
    endcase
  end
`else
  logic unused_stall;

  assign unused_stall = ^stall_cycles_i;
  assign gnt_raw      = bus.data_req_i;
`endif

  // Grant is suppressed in reset even while a request is asserted.
  assign gnt            = gnt_raw & ~n_reset;
  assign bus.data_gnt_o = gnt;

  assign mem_we        = gnt & bus.data_we_i & in_range;
  assign init_in_range = {1'b0, init_addr_i} < INIT_LIMIT;
  // A granted bus write to the same word overrides the preload entirely.
  assign init_we_eff   = init_we_i & init_in_range &
                         ~(mem_we && (init_addr_i[AW-1:0] == mem_addr));

  obi_resp_bytemem #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_mem (
    .clk       (clk),
    .we        (mem_we),
    .addr      (mem_addr),
    .be        (bus.data_be_i),
    .wdata     (bus.data_wdata_i),
    .init_we   (init_we_eff),
    .init_addr (init_addr_i[AW-1:0]),
    .init_wdata(init_wdata_i),
    .rdata     (mem_rdata)
  );

  always_comb begin
    rdata_next = 32'd0;
    oob_next   = oob_reg;
    if (gnt) begin
      if (!bus.data_we_i) begin
        rdata_next = in_range ? mem_rdata : BAD_DATA;
      end
      if (!in_range) begin
        oob_next = oob_sat_inc(oob_reg);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (n_reset) begin
      rvalid_reg <= 1'b0;
      rdata_reg  <= 32'd0;
      oob_reg    <= 8'd0;
    end else begin
      rvalid_reg <= gnt;
      rdata_reg  <= rdata_next;
      oob_reg    <= oob_next;
    end
  end

  assign bus.data_rvalid_o = rvalid_reg;
  assign bus.data_rdata_o  = rdata_reg;
  assign oob_count_o       = oob_reg;

endmodule

// File: tb/tb_obi_data_responder.sv
// Directed self-checking bench for obi_data_responder (DEPTH_WORDS=256).
module tb_obi_data_responder;

  logic        clk = 1'b0;
  logic        n_reset;
  logic [3:0]  stall_cycles;
  logic        init_we;
  logic [11:0] init_addr;
  logic [31:0] init_wdata;
  logic [7:0]  oob_count;

  int tests_run    = 0;
  int tests_failed = 0;
  int cur_stall    = 0;

  always #5 clk = ~clk;

  obi_data_responder_if bus ();

  obi_data_responder #(
    .DEPTH_WORDS(256),
    .BAD_DATA   (32'hDEAD_BEEF)
  ) dut (
    .clk           (clk),
    .n_reset       (n_reset),
    .bus           (bus.slave),
    .stall_cycles_i(stall_cycles),
    .init_we_i     (init_we),
    .init_addr_i   (init_addr),
    .init_wdata_i  (init_wdata),
    .oob_count_o   (oob_count)
  );

  task automatic check_val(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  task automatic preload(input logic [11:0] a, input logic [31:0] d);
    init_we    = 1'b1;
    init_addr  = a;
    init_wdata = d;
    @(posedge clk); #1;
    init_we    = 1'b0;
  endtask

  // Issues one request, checks grant latency, rvalid and rdata.
  task automatic do_access(input string tag, input logic we, input logic [31:0] addr,
                           input logic [3:0] be, input logic [31:0] wdata,
                           input logic [31:0] exp_rdata);
    int waited = 0;
    bus.data_req_i   = 1'b1;
    bus.data_we_i    = we;
    bus.data_addr_i  = addr;
    bus.data_be_i    = be;
    bus.data_wdata_i = wdata;
    #1;
    while (bus.data_gnt_o !== 1'b1 && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    check_val({tag, "_wait"}, 32'(waited), 32'(cur_stall));
    if (bus.data_gnt_o !== 1'b1) begin
      bus.data_req_i = 1'b0;
      return;
    end
    @(posedge clk); #1;
    bus.data_req_i = 1'b0;
    check_val({tag, "_rvalid"}, 32'(bus.data_rvalid_o), 32'd1);
    check_val({tag, "_rdata"}, bus.data_rdata_o, exp_rdata);
    $display("[TB] %s we=%0d addr=%h be=%b wdata=%h rdata=%h wait=%0d",
             tag, we, addr, be, wdata, bus.data_rdata_o, waited);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_reset          = 1'b1;
    stall_cycles     = 4'd0;
    init_we          = 1'b0;
    init_addr        = 12'd0;
    init_wdata       = 32'd0;
    bus.data_req_i   = 1'b1;
    bus.data_we_i    = 1'b0;
    bus.data_addr_i  = 32'h14;
    bus.data_be_i    = 4'hF;
    bus.data_wdata_i = 32'd0;

    // Reset state, with a request held to confirm the grant is masked.
    @(posedge clk); #1;
    check_val("rst_gnt", 32'(bus.data_gnt_o), 32'd0);
    check_val("rst_rvalid", 32'(bus.data_rvalid_o), 32'd0);
    check_val("rst_rdata", bus.data_rdata_o, 32'd0);
    check_val("rst_oob", 32'(oob_count), 32'd0);
    bus.data_req_i = 1'b0;
    @(posedge clk); #1;
    n_reset = 1'b0;

    preload(12'd5,   32'h1122_3344);
    preload(12'd0,   32'h0102_0304);
    preload(12'd7,   32'hCAFE_F00D);
    preload(12'd255, 32'hA5A5_0FF0);

    do_access("rd_preload", 1'b0, 32'h14, 4'hF, 32'd0, 32'h1122_3344);
    do_access("wr_be0101", 1'b1, 32'h14, 4'b0101, 32'hAABB_CCDD, 32'd0);
    do_access("rd_merged", 1'b0, 32'h14, 4'hF, 32'd0, 32'h11BB_33DD);
    do_access("rd_last", 1'b0, 32'h3FC, 4'hF, 32'd0, 32'hA5A5_0FF0);

    do_access("rd_oob", 1'b0, 32'h400, 4'hF, 32'd0, 32'hDEAD_BEEF);
    check_val("oob_after_rd", 32'(oob_count), 32'd1);
    do_access("wr_oob", 1'b1, 32'h400, 4'hF, 32'hFFFF_FFFF, 32'd0);
    check_val("oob_after_wr", 32'(oob_count), 32'd2);
    do_access("rd_word0", 1'b0, 32'h0, 4'hF, 32'd0, 32'h0102_0304);

    // Backdoor and bus write to the same word: bus wins.
    init_we = 1'b1; init_addr = 12'd5; init_wdata = 32'h5555_5555;
    do_access("wr_collide", 1'b1, 32'h14, 4'hF, 32'h6666_6666, 32'd0);
    init_we = 1'b0;
    do_access("rd_collide", 1'b0, 32'h14, 4'hF, 32'd0, 32'h6666_6666);

    // Backdoor and bus write to different words: both land.
    init_we = 1'b1; init_addr = 12'd6; init_wdata = 32'h7777_7777;
    do_access("wr_split", 1'b1, 32'h14, 4'b0001, 32'h0000_00AA, 32'd0);
    init_we = 1'b0;
    do_access("rd_split6", 1'b0, 32'h18, 4'hF, 32'd0, 32'h7777_7777);
    do_access("rd_split5", 1'b0, 32'h14, 4'hF, 32'd0, 32'h6666_66AA);
    do_access("wr_be1000", 1'b1, 32'h18, 4'b1000, 32'h9900_0000, 32'd0);
    do_access("rd_lowbits", 1'b0, 32'h1B, 4'hF, 32'd0, 32'h9977_7777);

`ifdef OBI_RESPONDER_STALL_EN
    stall_cycles = 4'd3;
    cur_stall    = 3;
    do_access("rd_stall3", 1'b0, 32'h14, 4'hF, 32'd0, 32'h6666_66AA);
    stall_cycles = 4'd5;
    cur_stall    = 0;
`endif

    // Reset while a request is pending: it must vanish without a response.
    bus.data_req_i  = 1'b1;
    bus.data_we_i   = 1'b0;
    bus.data_addr_i = 32'h1C;
`ifdef OBI_RESPONDER_STALL_EN
    @(posedge clk); #1;
    @(posedge clk); #1;
`endif
    n_reset = 1'b1;
    #1;
    check_val("rstreq_gnt0", 32'(bus.data_gnt_o), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_val("rstreq_gnt", 32'(bus.data_gnt_o), 32'd0);
      check_val("rstreq_rvalid", 32'(bus.data_rvalid_o), 32'd0);
    end
    bus.data_req_i = 1'b0;
    n_reset        = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_val("postrst_rvalid", 32'(bus.data_rvalid_o), 32'd0);
    end
    check_val("postrst_oob", 32'(oob_count), 32'd0);
    stall_cycles = 4'd0;
    do_access("rd_survive", 1'b0, 32'h1C, 4'hF, 32'd0, 32'hCAFE_F00D);

    // 300 back-to-back out-of-range reads saturate the counter.
    bus.data_req_i  = 1'b1;
    bus.data_we_i   = 1'b0;
    bus.data_addr_i = 32'h1000;
    for (int i = 1; i <= 300; i++) begin
      @(posedge clk); #1;
      if (i == 100) check_val("oob_mid", 32'(oob_count), 32'd100);
    end
    bus.data_req_i = 1'b0;
    check_val("oob_sat", 32'(oob_count), 32'd255);
    $display("[TB] oob burst of 300 reads oob_count=%0d", oob_count);
    do_access("rd_after_sat", 1'b0, 32'h1004, 4'hF, 32'd0, 32'hDEAD_BEEF);
    check_val("oob_hold", 32'(oob_count), 32'd255);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/obi_data_responder.md
OBI_DATA_RESPONDER -- requirements
Module: obi_data_responder

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 256, giving the number of 32-bit memory words (power of two, 16..4096).
REQ-002 The block SHALL have parameter BAD_DATA, default 32'hDEAD_BEEF, giving the rdata returned for out-of-range reads.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-004 The block SHALL have port n_reset, input, 1, the reset; it is synchronous and active-high (asserted = 1, despite the name).
REQ-005 The block SHALL have port data_req_i, input, 1, a request from the initiator.
REQ-006 The block SHALL have port data_gnt_o, output, 1, the request grant.
REQ-007 The block SHALL have port data_addr_i, input, 32, the byte address.
REQ-008 The block SHALL have port data_we_i, input, 1, where 1 = write and 0 = read.
REQ-009 The block SHALL have port data_be_i, input, 4, the byte enables.
REQ-010 The block SHALL have port data_wdata_i, input, 32, the write data.
REQ-011 The block SHALL have port data_rvalid_o, output, 1, the response valid.
REQ-012 The block SHALL have port data_rdata_o, output, 32, the response data.
REQ-013 The block SHALL have port stall_cycles_i, input, 4, the grant wait states per request (used only with the macro in REQ-030).
REQ-014 The block SHALL have port init_we_i, input, 1, the backdoor preload write strobe.
REQ-015 The block SHALL have port init_addr_i, input, 12, the backdoor word index.
REQ-016 The block SHALL have port init_wdata_i, input, 32, the backdoor data.
REQ-017 The block SHALL have port oob_count_o, output, 8, a saturating count of out-of-range accesses.

Function
REQ-018 The word index SHALL be data_addr_i[31:2]; addr[1:0] ignored; the access is out-of-range when the index >= DEPTH_WORDS.
REQ-019 The FSM SHALL have states IDLE and STALL; in IDLE with data_req_i=1 and effective stall S=0, data_gnt_o=1 in the same cycle (combinational from req).
REQ-020 For S>0, the FSM SHALL load counter=S and enter STALL on the first req cycle N, decrement each cycle, assert data_gnt_o when counter==1 (cycle N+S), then return to IDLE.
REQ-021 The initiator holds req/addr/we/be/wdata stable until grant; the block SHALL sample them only in the grant cycle.
REQ-022 On a granted write, each byte i with data_be_i[i]=1 SHALL be written at the grant edge; out-of-range writes SHALL be dropped.
REQ-023 On a granted read, data_rdata_o SHALL be the word value as of the grant edge (BAD_DATA if out-of-range), presented the cycle after grant.
REQ-024 data_rvalid_o SHALL pulse exactly one cycle, the cycle after every grant, for reads and writes; rdata SHALL be 0 for write responses.
REQ-025 Back-to-back grants SHALL be supported (one per cycle at S=0); a read granted the cycle after a write to the same word SHALL return the written bytes.
REQ-026 The backdoor write (init_we_i) SHALL take effect at the edge; if it coincides with a granted bus write to the same word, the bus write SHALL win.
REQ-027 Each granted out-of-range access SHALL increment oob_count_o, saturating at 255.

Reset
REQ-028 While n_reset=1: the FSM SHALL be IDLE, the counter 0, data_gnt_o=0, data_rvalid_o=0, data_rdata_o=0, oob_count_o=0; memory contents SHALL be preserved; a request in progress SHALL be abandoned without a response.
REQ-029 data_gnt_o SHALL be forced to 0 during reset even if data_req_i=1.

Configuration
REQ-030 Macro OBI_RESPONDER_STALL_EN: when defined, S=stall_cycles_i, sampled on the first req cycle; when undefined, S=0 always, stall_cycles_i is ignored, and the STALL state and counter SHALL NOT be synthesised.

Structure
REQ-031 The FSM state enum (obi_resp_state_t) and the OOB saturation constant SHALL live in accelerator_pkg.
REQ-032 Storage SHALL be one sub-module, obi_resp_bytemem: a byte-enabled single-write-port RAM with an asynchronous read.

Verification
REQ-033 Preload word 5 = 32'h1122_3344 via backdoor; read addr 0x14 at S=0 -> gnt in the same cycle, rvalid next cycle, rdata = 32'h1122_3344.
REQ-034 Write addr 0x14, be=4'b0101, wdata=32'hAABB_CCDD; read it next cycle -> rdata = 32'h11BB_33DD.
REQ-035 With the macro defined and stall_cycles_i=3, req at cycle 10 -> gnt at 13, rvalid at 14, no gnt at 10..12.
REQ-036 Read addr 0x400 with DEPTH_WORDS=256 -> rdata = 32'hDEAD_BEEF, oob_count_o = 1; a write to 0x400 leaves memory unchanged.
REQ-037 Assert n_reset during STALL -> no gnt or rvalid is ever issued for that request; the memory word preloaded before reset still reads back intact.
REQ-038 Issue 300 out-of-range accesses -> oob_count_o = 255.
